// File: rtl/lib_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Latency: none (types and helpers only).
// Backpressure: none (no datapath here).
package lib_pkg;

  typedef enum logic [1:0] {
    FS_INIT = 2'd0,
    FS_RUN  = 2'd1,
    FS_HALT = 2'd2
  } fetch_state_t;

  localparam int INST_BYTES = 4;

  // Saturating +1 for 32-bit event counters.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO holding {pc, instruction} pairs, with a same-cycle flush.
// Latency: a push is visible at the head the cycle after it is written; no bypass path.
// Backpressure: none internally; the producer's credit accounting guarantees space for every push.
module fetch_fifo
  import lib_pkg::*;
#(
  parameter  int PW    = 64,
  parameter  int DEPTH = 4,
  localparam int PTRW  = $clog2(DEPTH),
  localparam int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_flush,
  input  logic            i_push,
  input  logic [PW-1:0]   i_push_dat,
  input  logic            i_pop,
  output logic            o_vld,
  output logic [PW-1:0]   o_dat,
  output logic [CNTW-1:0] o_cnt
);

  logic [PW-1:0]   r_mem [DEPTH];
  logic [PTRW-1:0] r_wr_ptr;
  logic [PTRW-1:0] r_rd_ptr;
  logic [CNTW-1:0] r_cnt;
  logic            w_pop;

  // Popping an empty queue is a no-op.
  assign w_pop = i_pop & (r_cnt != '0);

  // Storage write; a flush suppresses the write of that cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  // Pointers and occupancy; flush empties the queue regardless of push/pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTRW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTRW'(1);
      r_cnt <= r_cnt + CNTW'(i_push) - CNTW'(w_pop);
    end
  end

  assign o_vld = (r_cnt != '0);
  assign o_dat = r_mem[r_rd_ptr];
  assign o_cnt = r_cnt;

  // A push into a full queue means the upstream credit accounting is broken.
  assert property (@(posedge clk) disable iff (!reset_n)
    !(i_push && !i_flush && (r_cnt == CNTW'(DEPTH))));

endmodule

// File: rtl/riscv_fetch_queue.sv
// Instruction-fetch front end: valid/ready imem port, in-order tag queue, prefetch FIFO, redirect flush.
// Latency: 1 cycle from imem response to inst_valid (no bypass); INIT spends one cycle before the first request.
// Backpressure: inst_ready low fills the FIFO; requests stop by credit (reads in flight + FIFO occupancy).
// Optional build macro FETCHQ_PERF_CNT_EN adds saturating perf_fetched/perf_dropped/perf_stall outputs.
module riscv_fetch_queue
  import lib_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int IADDR   = 16,
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] init_pc,
  input  logic             halt,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [IADDR-1:0] imem_addr,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [WIDTH-1:0] inst_data,
  output logic [WIDTH-1:0] inst_pc,
  output logic             busy
`ifdef FETCHQ_PERF_CNT_EN
  ,
  output logic [31:0]      perf_fetched,
  output logic [31:0]      perf_dropped,
  output logic [31:0]      perf_stall
`endif
);

  localparam int CW   = $clog2(MAX_OUT + 1);
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int TW   = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  fetch_state_t     r_state;
  logic [WIDTH-1:0] r_pc;
  logic [CW-1:0]    r_out;
  logic [CW-1:0]    r_drop;
  logic [WIDTH-1:0] r_tag [MAX_OUT];
  logic [TW-1:0]    r_tag_rd;
  logic [TW-1:0]    r_tag_wr;

  logic [CNTW-1:0]    w_cnt;
  logic [2*WIDTH-1:0] w_head;
  logic               w_credit_ok;
  logic               w_fire;
  logic               w_redir;
  logic               w_rsp_stale;
  logic               w_rsp_live;
  logic               w_rsp_any;
  logic               w_push;
  logic               w_pop;
  logic [1:0]         w_unused_pc_lsb;

  function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
    return (p == TW'(MAX_OUT - 1)) ? '0 : p + TW'(1);
  endfunction

  // Every read in flight (live or stale) holds a memory slot; every live read also reserves a FIFO slot.
  assign w_credit_ok = ((32'(r_out) + 32'(r_drop)) < 32'(MAX_OUT)) &&
                       ((32'(w_cnt) + 32'(r_out)) < 32'(DEPTH));
  assign imem_req_valid = (r_state == FS_RUN) & ~redirect & w_credit_ok;
  assign w_fire         = imem_req_valid & imem_req_ready;
  assign imem_addr      = r_pc[IADDR-1:0];

  // Halt beats redirect; redirect only acts while running.
  assign w_redir     = redirect & (r_state == FS_RUN) & ~halt;
  // Stale responses drain first because memory answers in order.
  assign w_rsp_stale = imem_rsp_valid & (r_drop != '0);
  assign w_rsp_live  = imem_rsp_valid & (r_drop == '0) & (r_out != '0);
  assign w_rsp_any   = w_rsp_stale | w_rsp_live;
  assign w_push      = w_rsp_live & ~w_redir;
  assign w_pop       = inst_valid & inst_ready;

  assign w_unused_pc_lsb = redirect_pc[1:0];

  // Fetch FSM and program counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= FS_INIT;
      r_pc    <= '0;
    end else begin
      case (r_state)
        FS_INIT: begin
          r_pc    <= init_pc;
          r_state <= FS_RUN;
        end
        FS_RUN: begin
          if (halt) r_state <= FS_HALT;
          if (w_redir)     r_pc <= {redirect_pc[WIDTH-1:2], 2'b00};
          else if (w_fire) r_pc <= r_pc + WIDTH'(INST_BYTES);
        end
        default: r_state <= r_state;
      endcase
    end
  end

  // Live/stale read counters; on redirect every live read becomes stale.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out  <= '0;
      r_drop <= '0;
    end else if (w_redir) begin
      r_out  <= '0;
      r_drop <= r_drop + r_out - CW'(w_rsp_any);
    end else begin
      r_out  <= r_out + CW'(w_fire) - CW'(w_rsp_live);
      r_drop <= r_drop - CW'(w_rsp_stale);
    end
  end

  // Tag ring remembering the PC of each live read; stale reads never consult it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAX_OUT; i++) r_tag[i] <= '0;
      r_tag_rd <= '0;
      r_tag_wr <= '0;
    end else if (w_redir) begin
      r_tag_rd <= '0;
      r_tag_wr <= '0;
    end else begin
      if (w_fire) begin
        r_tag[r_tag_wr] <= r_pc;
        r_tag_wr        <= tag_inc(r_tag_wr);
      end
      if (w_rsp_live) r_tag_rd <= tag_inc(r_tag_rd);
    end
  end

  fetch_fifo #(
    .PW    (2 * WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_flush    (w_redir),
    .i_push     (w_push),
    .i_push_dat ({r_tag[r_tag_rd], imem_rsp_data}),
    .i_pop      (w_pop),
    .o_vld      (inst_valid),
    .o_dat      (w_head),
    .o_cnt      (w_cnt)
  );

  assign inst_pc   = w_head[2*WIDTH-1:WIDTH];
  assign inst_data = w_head[WIDTH-1:0];
  assign busy      = ((r_out | r_drop) != '0);

`ifdef FETCHQ_PERF_CNT_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_dropped;
  logic [31:0] r_perf_stall;

  // Event counters: delivered-to-FIFO reads, discarded responses, decode stall cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_fetched <= '0;
      r_perf_dropped <= '0;
      r_perf_stall   <= '0;
    end else begin
      r_perf_fetched <= sat_inc32(r_perf_fetched, w_push);
      r_perf_dropped <= sat_inc32(r_perf_dropped, imem_rsp_valid & ~w_push);
      r_perf_stall   <= sat_inc32(r_perf_stall, inst_valid & ~inst_ready);
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_dropped = r_perf_dropped;
  assign perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Self-checking bench for riscv_fetch_queue: queue-based reference model plus directed scenario checks.
// Latency: model is cycle-exact on the outputs; memory model answers in order after a programmable delay.
// Backpressure: inst_ready and imem_req_ready are driven from per-phase percentages.
module tb_riscv_fetch_queue;

  localparam int WIDTH   = 32;
  localparam int IADDR   = 16;
  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [WIDTH-1:0] init_pc;
  logic             halt;
  logic             redirect;
  logic [WIDTH-1:0] redirect_pc;
  logic             imem_req_valid;
  logic             imem_req_ready;
  logic [IADDR-1:0] imem_addr;
  logic             imem_rsp_valid;
  logic [WIDTH-1:0] imem_rsp_data;
  logic             inst_valid;
  logic             inst_ready;
  logic [WIDTH-1:0] inst_data;
  logic [WIDTH-1:0] inst_pc;
  logic             busy;
`ifdef FETCHQ_PERF_CNT_EN
  logic [31:0]      perf_fetched;
  logic [31:0]      perf_dropped;
  logic [31:0]      perf_stall;
`endif

  always #5 clk = ~clk;

  riscv_fetch_queue #(
    .WIDTH(WIDTH), .IADDR(IADDR), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .init_pc        (init_pc),
    .halt           (halt),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .busy           (busy)
`ifdef FETCHQ_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_dropped   (perf_dropped),
    .perf_stall     (perf_stall)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end
  endtask

  // Reference model: 0=INIT 1=RUN 2=HALT, pc, FIFO contents, PCs of live reads, stale-read count.
  int          m_state;
  logic [31:0] m_pc;
  logic [63:0] m_fifo [$];
  logic [31:0] m_live [$];
  int          m_drop;
  int          m_pushes;

  // Memory model: accepted reads with their due cycle, answered in order.
  typedef struct {
    logic [15:0] addr;
    int          due;
  } mreq_t;
  mreq_t memq [$];
  int    last_due;
  int    max_inflight;

  // Stimulus knobs.
  int          ready_pct = 100;
  int          rreq_pct  = 100;
  int          lat_lo    = 1;
  int          lat_hi    = 1;
  int          redir_pct = 0;
  logic        halt_lvl  = 1'b0;
  logic        redir_pend = 1'b0;
  logic [31:0] redir_target;

  // Observed deliveries.
  logic [31:0] got_pc  [$];
  int          got_cyc [$];
  int          cyc;

  function automatic logic [31:0] mem_data(input logic [15:0] a);
    return 32'hA5C3_0000 ^ {a, ~a};
  endfunction

  // One clock cycle: drive at negedge, compare after settling, advance model and memory.
  task automatic step();
    logic        exp_iv, exp_rv, exp_busy, rsp_v, fire_m, pop_m, redir_m, dut_fire;
    logic [31:0] tpc;
    int          due;
    mreq_t       r;
    @(negedge clk);
    inst_ready     = ($urandom_range(1, 100) <= ready_pct);
    imem_req_ready = ($urandom_range(1, 100) <= rreq_pct);
    halt           = halt_lvl;
    if (redir_pend) begin
      redirect    = 1'b1;
      redirect_pc = redir_target;
      redir_pend  = 1'b0;
    end else if (redir_pct > 0 && $urandom_range(1, 1000) <= redir_pct) begin
      redirect    = 1'b1;
      redirect_pc = 32'($urandom_range(0, 32'hFFFF));
    end else begin
      redirect    = 1'b0;
      redirect_pc = $urandom;
    end
    rsp_v          = (memq.size() > 0) && (memq[0].due <= cyc);
    imem_rsp_valid = rsp_v;
    imem_rsp_data  = rsp_v ? mem_data(memq[0].addr) : $urandom;
    #1;
    exp_iv   = (m_fifo.size() != 0);
    exp_rv   = (m_state == 1) && !redirect && (m_live.size() + m_drop < MAX_OUT) &&
               (m_fifo.size() + m_live.size() < DEPTH);
    exp_busy = (m_live.size() + m_drop) != 0;
    check("inst_valid", inst_valid, exp_iv);
    if (exp_iv) begin
      check("inst_pc", inst_pc, m_fifo[0][63:32]);
      check("inst_data", inst_data, m_fifo[0][31:0]);
    end
    check("req_valid", imem_req_valid, exp_rv);
    if (exp_rv) check("imem_addr", imem_addr, m_pc[15:0]);
    check("busy", busy, exp_busy);
    if (inst_valid && inst_ready) begin
      got_pc.push_back(inst_pc);
      got_cyc.push_back(cyc);
    end
    dut_fire = imem_req_valid && imem_req_ready;
    // model advance
    fire_m  = exp_rv && imem_req_ready;
    pop_m   = exp_iv && inst_ready;
    redir_m = redirect && (m_state == 1) && !halt;
    if (pop_m) void'(m_fifo.pop_front());
    if (rsp_v) begin
      if (m_drop > 0) m_drop--;
      else if (m_live.size() > 0) begin
        tpc = m_live.pop_front();
        if (!redir_m) begin
          m_fifo.push_back({tpc, imem_rsp_data});
          m_pushes++;
        end
      end
    end
    if (redir_m) begin
      m_drop += m_live.size();
      m_live.delete();
      m_fifo.delete();
      m_pc = redirect_pc & ~32'h3;
    end else if (fire_m) begin
      m_live.push_back(m_pc);
      m_pc = m_pc + 32'd4;
    end
    case (m_state)
      0:       begin m_pc = init_pc; m_state = 1; end
      1:       if (halt) m_state = 2;
      default: ;
    endcase
    // memory advance
    if (rsp_v) void'(memq.pop_front());
    if (dut_fire) begin
      due = cyc + $urandom_range(lat_lo, lat_hi);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      r.addr = imem_addr;
      r.due  = due;
      memq.push_back(r);
    end
    if (memq.size() > max_inflight) max_inflight = memq.size();
    cyc++;
  endtask

  initial begin
    int mark, gaps, occ;
    logic [31:0] popped;
    reset_n = 1'b0; init_pc = 32'h100; halt = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; inst_ready = 1'b0;
    m_state = 0; m_pc = '0; m_drop = 0; m_pushes = 0; last_due = -1; max_inflight = 0; cyc = 0;

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_inst_pc", inst_pc, 0);
    check("rst_inst_data", inst_data, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #2 reset_n = 1'b1;

    // Zero-wait memory, decode always ready; a redirect during INIT must be ignored.
    redir_target = 32'h900; redir_pend = 1'b1;
    repeat (20) step();
    check("p2_count", got_pc.size() >= 8, 1);
    for (int i = 0; i < 8; i++) begin
      if (i < got_pc.size()) begin
        check($sformatf("p2_pc%0d", i), got_pc[i], 32'h100 + 4 * i);
        check($sformatf("p2_cyc%0d", i), got_cyc[i], 3 + i);
      end
    end

    // Fixed 3-cycle latency: never more than MAX_OUT in flight, contiguous PCs.
    lat_lo = 3; lat_hi = 3; max_inflight = 0; mark = got_pc.size();
    repeat (40) step();
    check("p3_max_inflight", max_inflight, MAX_OUT);
    gaps = 0;
    for (int i = mark + 1; i < got_pc.size(); i++) if (got_pc[i] != got_pc[i-1] + 32'd4) gaps++;
    check("p3_gaps", gaps, 0);

    // Decode stalled for 10 cycles: FIFO fills, requests stop, no reads left in flight.
    lat_lo = 1; lat_hi = 1; ready_pct = 0;
    repeat (10) step();
    check("p4_req_stopped", imem_req_valid, 0);
    check("p4_idle", busy, 0);
    check("p4_head_valid", inst_valid, 1);
    ready_pct = 100;
    repeat (20) step();

    // Redirect to 0x200 with two reads in flight.
    lat_lo = 3; lat_hi = 3;
    for (int i = 0; i < 30 && memq.size() != 2; i++) step();
    check("p5_two_inflight", memq.size(), 2);
    ready_pct = 0; redir_target = 32'h200; redir_pend = 1'b1;
    step();
    mark = got_pc.size();
    repeat (25) step();
    check("p5_busy_low", busy, 0);
    ready_pct = 100;
    repeat (10) step();
    if (got_pc.size() > mark + 1) begin
      check("p5_first_pc", got_pc[mark], 32'h200);
      check("p5_second_pc", got_pc[mark+1], 32'h204);
    end else check("p5_deliveries", got_pc.size(), mark + 2);

    // Redirect coinciding with a response and a pop.
    lat_lo = 1; lat_hi = 1;
    repeat (10) step();
    mark = got_pc.size();
    check("p6_rsp_pending", memq.size() > 0 && memq[0].due <= cyc, 1);
    redir_target = 32'h300; redir_pend = 1'b1;
    step();
    check("p6_pop_on_redirect", got_pc.size(), mark + 1);
    popped = (got_pc.size() > mark) ? got_pc[mark] : 32'hFFFF_FFFF;
    step();
    check("p6_empty_after", got_pc.size(), mark + 1);
    repeat (10) step();
    if (got_pc.size() > mark + 1) check("p6_next_pc", got_pc[mark+1], 32'h300);
    occ = 0;
    for (int i = 0; i < got_pc.size(); i++) if (got_pc[i] == popped) occ++;
    check("p6_popped_once", occ, 1);

    // Randomized traffic with random latency, stalls and redirects.
    lat_lo = 1; lat_hi = 5; ready_pct = 70; rreq_pct = 75; redir_pct = 15;
    repeat (3000) step();

    // Halt: requests stop, queued entries drain, later redirects ignored.
    redir_pct = 0; rreq_pct = 100; ready_pct = 0; lat_lo = 2; lat_hi = 2;
    repeat (15) step();
    mark = got_pc.size();
    halt_lvl = 1'b1;
    step();
    step();
    check("p8_req_low", imem_req_valid, 0);
    ready_pct = 100; redir_target = 32'h400; redir_pend = 1'b1;
    repeat (20) step();
    check("p8_drained", got_pc.size() - mark, DEPTH);
    occ = 0;
    for (int i = mark; i < got_pc.size(); i++) if (got_pc[i] == 32'h400) occ++;
    check("p8_redirect_ignored", occ, 0);
    check("p8_empty", inst_valid, 0);
    check("p8_idle", busy, 0);
`ifdef FETCHQ_PERF_CNT_EN
    check("perf_fetched", perf_fetched, m_pushes);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
